elevator_request_latch: RTL and testbench

//  Front end for the elevator controller. Synchronises, debounces and latches all car/hall

---
 rtl/elevator_pkg.sv | 34 +++
 rtl/button_debouncer.sv | 59 +++++
 rtl/elevator_request_latch.sv | 131 +++++++++++++
 tb/tb_elevator_request_latch.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request front end.
//   FLOOR_W / NUM_FLOORS : floor encoding width and floor count
//   dir_e / decode_dir   : travel direction decoded from controller up/down lines
//   BTN_*                : bit positions inside the 12-bit raw button bus
package elevator_pkg;

  localparam int unsigned FLOOR_W    = 2;
  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned NUM_HALL   = NUM_FLOORS - 1;
  localparam int unsigned NUM_BTNS   = 12;

  // Raw button bus layout: car calls, hall-up (floors 0..2), hall-down (floors 1..3), door.
  localparam int unsigned BTN_CAR0   = 0;
  localparam int unsigned BTN_UP0    = 4;
  localparam int unsigned BTN_DN1    = 7;
  localparam int unsigned BTN_DOPEN  = 10;
  localparam int unsigned BTN_DCLOSE = 11;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Both lines high is treated like idle: each direction then serves its own calls.
  function automatic dir_e decode_dir(input logic up, input logic down);
    dir_e dir;
    dir = DIR_IDLE;
    if (up && !down) dir = DIR_UP;
    else if (down && !up) dir = DIR_DOWN;
    return dir;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button channel: 2-flop synchroniser, counter debouncer, rising-edge detector.
//   clk, reset : clock and synchronous active-high reset
//   raw        : asynchronous button line
//   level      : debounced button level
//   press      : one-cycle pulse when the debounced level rises
module button_debouncer #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Accept a new level only after DB_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/elevator_request_latch.sv
// Elevator button front end: debounces all buttons, latches car/hall calls until served,
// emits door-command pulses and above/below/here request summaries.
//   Inputs : clk, reset, raw buttons (F1..F4, F1up..F3up, F2down..F4down, Dopen, Dclose),
//            controller state floor, door_open, up, down
//   Outputs: car_req, hall_up_req, hall_dn_req (pending calls), door_open_pulse,
//            door_close_pulse (registered pulses), req_here/above/below (combinational)
module elevator_request_latch
  import elevator_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  F1,
  input  logic                  F2,
  input  logic                  F3,
  input  logic                  F4,
  input  logic                  F1up,
  input  logic                  F2up,
  input  logic                  F3up,
  input  logic                  F2down,
  input  logic                  F3down,
  input  logic                  F4down,
  input  logic                  Dopen,
  input  logic                  Dclose,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  door_open,
  input  logic                  up,
  input  logic                  down,
  output logic [NUM_FLOORS-1:0] car_req,
  output logic [NUM_HALL-1:0]   hall_up_req,
  output logic [NUM_HALL-1:0]   hall_dn_req,
  output logic                  door_open_pulse,
  output logic                  door_close_pulse,
  output logic                  req_here,
  output logic                  req_above,
  output logic                  req_below
);

  logic [NUM_BTNS-1:0]   btn_raw;
  logic [NUM_BTNS-1:0]   btn_press;
  logic [NUM_BTNS-1:0]   btn_level_unused;

  logic [NUM_FLOORS-1:0] car_q, car_d;
  logic [NUM_HALL-1:0]   hall_up_q, hall_up_d;
  logic [NUM_HALL-1:0]   hall_dn_q, hall_dn_d;
  logic                  open_pulse_q, open_pulse_d;
  logic                  close_pulse_q, close_pulse_d;

  logic [NUM_FLOORS-1:0] clr_car;
  logic [NUM_HALL-1:0]   clr_up;
  logic [NUM_HALL-1:0]   clr_dn;
  logic [NUM_FLOORS-1:0] floor_any;
  dir_e                  dir;

  assign btn_raw = {Dclose, Dopen, F4down, F3down, F2down, F3up, F2up, F1up, F4, F3, F2, F1};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debouncer #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[i]),
      .level (btn_level_unused[i]),
      .press (btn_press[i])
    );
  end

  // Serve conditions: hall calls are served only when travel direction matches or idle.
  always_comb begin
    dir     = decode_dir(up, down);
    clr_car = '0;
    clr_up  = '0;
    clr_dn  = '0;
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      clr_car[f] = door_open && (floor == FLOOR_W'(f));
    end
    for (int unsigned h = 0; h < NUM_HALL; h++) begin
      clr_up[h] = door_open && (floor == FLOOR_W'(h))     && (dir != DIR_DOWN);
      clr_dn[h] = door_open && (floor == FLOOR_W'(h + 1)) && (dir != DIR_UP);
    end
  end

  // Pending next state: clear takes priority over a same-cycle press.
  always_comb begin
    car_d         = (car_q     | btn_press[BTN_CAR0 +: NUM_FLOORS]) & ~clr_car;
    hall_up_d     = (hall_up_q | btn_press[BTN_UP0  +: NUM_HALL])   & ~clr_up;
    hall_dn_d     = (hall_dn_q | btn_press[BTN_DN1  +: NUM_HALL])   & ~clr_dn;
    open_pulse_d  = btn_press[BTN_DOPEN];
    close_pulse_d = btn_press[BTN_DCLOSE] & ~btn_press[BTN_DOPEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      car_q         <= '0;
      hall_up_q     <= '0;
      hall_dn_q     <= '0;
      open_pulse_q  <= 1'b0;
      close_pulse_q <= 1'b0;
    end else begin
      car_q         <= car_d;
      hall_up_q     <= hall_up_d;
      hall_dn_q     <= hall_dn_d;
      open_pulse_q  <= open_pulse_d;
      close_pulse_q <= close_pulse_d;
    end
  end

  // Per-floor OR of all call types; hall-down bit i belongs to floor i+1.
  always_comb begin
    floor_any = car_q | {1'b0, hall_up_q} | {hall_dn_q, 1'b0};
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      if (floor_any[f]) begin
        if (FLOOR_W'(f) == floor) req_here  = 1'b1;
        if (FLOOR_W'(f) >  floor) req_above = 1'b1;
        if (FLOOR_W'(f) <  floor) req_below = 1'b1;
      end
    end
  end

  assign car_req          = car_q;
  assign hall_up_req      = hall_up_q;
  assign hall_dn_req      = hall_dn_q;
  assign door_open_pulse  = open_pulse_q;
  assign door_close_pulse = close_pulse_q;

endmodule

// File: tb/tb_elevator_request_latch.sv
// Directed self-checking bench for elevator_request_latch (DB_CYCLES = 4).
module tb_elevator_request_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] btn;
  logic [1:0]  floor;
  logic        door_open, up, down;
  logic [3:0]  car_req;
  logic [2:0]  hall_up_req, hall_dn_req;
  logic        door_open_pulse, door_close_pulse;
  logic        req_here, req_above, req_below;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  elevator_request_latch #(.DB_CYCLES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .F1               (btn[0]),
    .F2               (btn[1]),
    .F3               (btn[2]),
    .F4               (btn[3]),
    .F1up             (btn[4]),
    .F2up             (btn[5]),
    .F3up             (btn[6]),
    .F2down           (btn[7]),
    .F3down           (btn[8]),
    .F4down           (btn[9]),
    .Dopen            (btn[10]),
    .Dclose           (btn[11]),
    .floor            (floor),
    .door_open        (door_open),
    .up               (up),
    .down             (down),
    .car_req          (car_req),
    .hall_up_req      (hall_up_req),
    .hall_dn_req      (hall_dn_req),
    .door_open_pulse  (door_open_pulse),
    .door_close_pulse (door_close_pulse),
    .req_here         (req_here),
    .req_above        (req_above),
    .req_below        (req_below)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn = '0; floor = 2'd0; door_open = 1'b0; up = 1'b0; down = 1'b0;
    tick(3);
    reset = 1'b0;
  endtask

  // Hold a set of buttons for 5 clocks, release, and let the release debounce.
  task automatic press_btns(input logic [11:0] mask);
    btn = mask;
    tick(5);
    btn = '0;
    tick(10);
  endtask

  int n_open, n_close, at_open, at_close;

  initial begin
    // Reset with every button held: nothing may leak through.
    reset = 1'b1;
    btn = '1; floor = 2'd0; door_open = 1'b0; up = 1'b0; down = 1'b0;
    tick(4);
    check("rst_car",  32'(car_req), 32'h0);
    check("rst_hup",  32'(hall_up_req), 32'h0);
    check("rst_hdn",  32'(hall_dn_req), 32'h0);
    check("rst_pul",  32'({door_open_pulse, door_close_pulse}), 32'h0);
    check("rst_sum",  32'({req_here, req_above, req_below}), 32'h0);
    // Release reset with F3 held: accepted exactly 7 clocks later.
    btn = 12'h004;
    reset = 1'b0;
    tick(6);
    check("rst_f3_6clk", 32'(car_req), 32'h0);
    tick(1);
    check("rst_f3_7clk", 32'(car_req), 32'h4);

    // Glitch rejection on F2up.
    do_reset();
    btn[5] = 1'b1; tick(3); btn[5] = 1'b0; tick(10);
    check("glitch3", 32'(hall_up_req), 32'h0);
    btn[5] = 1'b1; tick(4); btn[5] = 1'b0; tick(10);
    check("glitch4", 32'(hall_up_req), 32'h2);

    // Serve with direction: up keeps the hall-down call at the same floor.
    do_reset();
    press_btns(12'h0A0);            // F2up (bit5) + F2down (bit7)
    check("dir_pend_up", 32'(hall_up_req), 32'h2);
    check("dir_pend_dn", 32'(hall_dn_req), 32'h1);
    floor = 2'd1; door_open = 1'b1; up = 1'b1;
    tick(1);
    check("dir_up_hup", 32'(hall_up_req), 32'h0);
    check("dir_up_hdn", 32'(hall_dn_req), 32'h1);
    up = 1'b0;
    tick(1);
    check("dir_idle_hdn", 32'(hall_dn_req), 32'h0);

    // Set/clear collision at floor 2: clear wins.
    do_reset();
    floor = 2'd2;
    btn[2] = 1'b1;
    tick(6);
    door_open = 1'b1;
    tick(1);
    door_open = 1'b0;
    tick(5);
    check("coll_served", 32'(car_req), 32'h0);
    btn[2] = 1'b0; tick(10);
    btn[2] = 1'b1; tick(10);
    check("coll_closed", 32'(car_req), 32'h4);
    btn[2] = 1'b0;

    // Summaries.
    do_reset();
    press_btns(12'h009);            // F1 + F4
    check("sum_car", 32'(car_req), 32'h9);
    floor = 2'd1; #1;
    check("sum_f1", 32'({req_here, req_above, req_below}), 32'b011);
    floor = 2'd0; #1;
    check("sum_f0", 32'({req_here, req_above, req_below}), 32'b110);
    door_open = 1'b1; tick(1); door_open = 1'b0;
    floor = 2'd3; #1;
    check("sum_only3", 32'(car_req), 32'h8);
    check("sum_f3", 32'({req_here, req_above, req_below}), 32'b100);

    // Door pulses: simultaneous open/close presses.
    do_reset();
    btn[10] = 1'b1; btn[11] = 1'b1;
    n_open = 0; n_close = 0; at_open = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (door_open_pulse)  begin n_open++; at_open = i; end
      if (door_close_pulse) n_close++;
    end
    check("door_both_open",  32'(n_open), 32'd1);
    check("door_both_at",    32'(at_open), 32'd7);
    check("door_both_close", 32'(n_close), 32'd0);
    btn = '0; tick(12);
    // Dclose held 20 clocks (door closed): exactly one close pulse.
    btn[11] = 1'b1;
    n_open = 0; n_close = 0; at_close = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (door_open_pulse)  n_open++;
      if (door_close_pulse) begin n_close++; at_close = i; end
    end
    check("door_close_cnt",  32'(n_close), 32'd1);
    check("door_close_at",   32'(at_close), 32'd7);
    check("door_close_open", 32'(n_open), 32'd0);
    btn = '0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
